// File: rtl/dest_tag_tracker.sv
// dest_tag_tracker
//
// Return-route tracker for NoC slave translators. Each accepted request
// stores its return {tag, dst, vc} in one of NUM_CHANNELS in-order queues.
// The reply path pops the head of the channel it is serving.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   i_dst_in/i_vc_in/i_tag_in entry to push
//   i_chan_in, i_valid_in     push channel select and push request
//   i_ready_out               selected push channel is not full
//   o_chan_in, o_valid_in     head channel select and pop request
//   o_dst_out/o_vc_out/o_tag_out  head entry of o_chan_in (0 when empty)
//   o_valid_out               head channel holds an entry
//   o_count_out               per-channel occupancy, channel c at [c*CNT_W +: CNT_W]
//   o_afull_out               per-channel occupancy >= ALMOST_FULL
//   err_overflow_out          sticky: push attempted to a full channel
//   err_underflow_out         sticky: pop attempted from an empty channel
//
// Build option:
//   DEST_TAG_TRACKER_BYPASS_EN  a push into an empty head channel is shown on
//                               the head outputs in the same cycle and can be
//                               consumed by a same-cycle pop without being stored.

module dest_tag_tracker #(
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int TAG_WIDTH        = 8,
    parameter int NUM_CHANNELS     = 2,
    parameter int DEPTH            = 12,
    parameter int ALMOST_FULL      = DEPTH - 2,
    localparam int CHAN_W          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int CNT_W           = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDRESS_WIDTH-1:0]       i_dst_in,
    input  logic [VC_ADDRESS_WIDTH-1:0]    i_vc_in,
    input  logic [TAG_WIDTH-1:0]           i_tag_in,
    input  logic [CHAN_W-1:0]              i_chan_in,
    input  logic                           i_valid_in,
    output logic                           i_ready_out,
    input  logic [CHAN_W-1:0]              o_chan_in,
    output logic [ADDRESS_WIDTH-1:0]       o_dst_out,
    output logic [VC_ADDRESS_WIDTH-1:0]    o_vc_out,
    output logic [TAG_WIDTH-1:0]           o_tag_out,
    output logic                           o_valid_out,
    input  logic                           o_valid_in,
    output logic [NUM_CHANNELS*CNT_W-1:0]  o_count_out,
    output logic [NUM_CHANNELS-1:0]        o_afull_out,
    output logic                           err_overflow_out,
    output logic                           err_underflow_out
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = TAG_WIDTH + ADDRESS_WIDTH + VC_ADDRESS_WIDTH;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(ALMOST_FULL);

    // Entry storage is never reset; only pointers, counts and flags are.
    logic [ENTRY_W-1:0] r_mem [NUM_CHANNELS][DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr [NUM_CHANNELS];
    logic [PTR_W-1:0]   r_rd_ptr [NUM_CHANNELS];
    logic [CNT_W-1:0]   r_cnt [NUM_CHANNELS];
    logic               r_err_ovf;
    logic               r_err_unf;

    logic [NUM_CHANNELS-1:0] w_push_sel;
    logic [NUM_CHANNELS-1:0] w_pop_sel;
    logic [NUM_CHANNELS-1:0] w_full;
    logic [NUM_CHANNELS-1:0] w_empty;
    logic [NUM_CHANNELS-1:0] w_push;
    logic [NUM_CHANNELS-1:0] w_pop;
    logic [ENTRY_W-1:0]      w_in_entry;
    logic [ENTRY_W-1:0]      w_head_entry;
    logic [ENTRY_W-1:0]      w_out_entry;
    logic                    w_head_valid;
    logic                    w_bypass;
    logic                    w_bypass_pop;
    logic                    w_out_valid;

    assign w_in_entry = {i_tag_in, i_dst_in, i_vc_in};

    // One-hot channel decode; a select value beyond NUM_CHANNELS-1 matches
    // nothing, so it reads as full (no push) and empty (no head).
    always_comb begin
        w_push_sel = '0;
        w_pop_sel  = '0;
        w_full     = '0;
        w_empty    = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_push_sel[c] = (i_chan_in == CHAN_W'(c));
            w_pop_sel[c]  = (o_chan_in == CHAN_W'(c));
            w_full[c]     = (r_cnt[c] == FULL_CNT);
            w_empty[c]    = (r_cnt[c] == '0);
        end
    end

    assign i_ready_out = |(w_push_sel & ~w_full);

    // Head read; stays zero unless the selected channel holds an entry.
    always_comb begin
        w_head_entry = '0;
        w_head_valid = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (w_pop_sel[c] && !w_empty[c]) begin
                w_head_entry = r_mem[c][r_rd_ptr[c]];
                w_head_valid = 1'b1;
            end
        end
    end

`ifdef DEST_TAG_TRACKER_BYPASS_EN
    // An accepted push into the empty head channel is forwarded straight to
    // the head outputs; a same-cycle pop consumes it so nothing is stored.
    assign w_bypass     = !w_head_valid && i_valid_in && i_ready_out &&
                          (i_chan_in == o_chan_in);
    assign w_bypass_pop = w_bypass && o_valid_in;
`else
    assign w_bypass     = 1'b0;
    assign w_bypass_pop = 1'b0;
`endif

    assign w_out_valid = w_head_valid | w_bypass;
    assign w_out_entry = w_bypass ? w_in_entry : w_head_entry;

    assign {o_tag_out, o_dst_out, o_vc_out} = w_out_entry;
    assign o_valid_out       = w_out_valid;
    assign err_overflow_out  = r_err_ovf;
    assign err_underflow_out = r_err_unf;

    always_comb begin
        w_push = '0;
        w_pop  = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_push[c] = i_valid_in && w_push_sel[c] && !w_full[c] && !w_bypass_pop;
            w_pop[c]  = o_valid_in && w_pop_sel[c] && !w_empty[c];
        end
    end

    always_comb begin
        o_count_out = '0;
        o_afull_out = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            o_count_out[c*CNT_W +: CNT_W] = r_cnt[c];
            o_afull_out[c]                = (r_cnt[c] >= AF_CNT);
        end
    end

    // Pointer/count/flag state. Pointers wrap by explicit compare so any
    // DEPTH works, not only powers of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
                r_cnt[c]    <= '0;
            end
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (w_push[c]) begin
                    r_wr_ptr[c] <= (r_wr_ptr[c] == LAST_PTR) ? '0 : r_wr_ptr[c] + 1'b1;
                end
                if (w_pop[c]) begin
                    r_rd_ptr[c] <= (r_rd_ptr[c] == LAST_PTR) ? '0 : r_rd_ptr[c] + 1'b1;
                end
                case ({w_push[c], w_pop[c]})
                    2'b10:   r_cnt[c] <= r_cnt[c] + 1'b1;
                    2'b01:   r_cnt[c] <= r_cnt[c] - 1'b1;
                    default: r_cnt[c] <= r_cnt[c];
                endcase
            end
            if (i_valid_in && !i_ready_out) begin
                r_err_ovf <= 1'b1;
            end
            if (o_valid_in && !w_out_valid) begin
                r_err_unf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (w_push[c]) begin
                r_mem[c][r_wr_ptr[c]] <= w_in_entry;
            end
        end
    end

endmodule

// File: tb/tb_dest_tag_tracker.sv
`timescale 1ns/1ps
module tb_dest_tag_tracker;

    localparam int AW     = 4;
    localparam int VW     = 1;
    localparam int TW     = 8;
    localparam int NC     = 2;
    localparam int DEPTH  = 12;
    localparam int CHAN_W = 1;
    localparam int CNT_W  = 4;
    localparam int AF     = DEPTH - 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [AW-1:0]     i_dst_in;
    logic [VW-1:0]     i_vc_in;
    logic [TW-1:0]     i_tag_in;
    logic [CHAN_W-1:0] i_chan_in;
    logic              i_valid_in;
    logic              i_ready_out;
    logic [CHAN_W-1:0] o_chan_in;
    logic [AW-1:0]     o_dst_out;
    logic [VW-1:0]     o_vc_out;
    logic [TW-1:0]     o_tag_out;
    logic              o_valid_out;
    logic              o_valid_in;
    logic [NC*CNT_W-1:0] o_count_out;
    logic [NC-1:0]     o_afull_out;
    logic              err_overflow_out;
    logic              err_underflow_out;

    dest_tag_tracker #(
        .ADDRESS_WIDTH(AW), .VC_ADDRESS_WIDTH(VW), .TAG_WIDTH(TW),
        .NUM_CHANNELS(NC), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .i_dst_in(i_dst_in), .i_vc_in(i_vc_in), .i_tag_in(i_tag_in),
        .i_chan_in(i_chan_in), .i_valid_in(i_valid_in), .i_ready_out(i_ready_out),
        .o_chan_in(o_chan_in), .o_dst_out(o_dst_out), .o_vc_out(o_vc_out),
        .o_tag_out(o_tag_out), .o_valid_out(o_valid_out), .o_valid_in(o_valid_in),
        .o_count_out(o_count_out), .o_afull_out(o_afull_out),
        .err_overflow_out(err_overflow_out), .err_underflow_out(err_underflow_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          mcnt [2];
    bit          m_ovf, m_unf;
    logic [12:0] q0 [$];
    logic [12:0] q1 [$];
    bit          exp_pop_ok;
    bit          byp_cyc;
    bit          m_acc, m_pok;
    logic        m_pc, m_rc;

    logic [12:0] mon_exp;
    bit          mon_have;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every pop the bench issues is compared here.
    always @(negedge clk) begin
        if (!rst && o_valid_in) begin
            chk("pop_valid", o_valid_out, exp_pop_ok);
            if (o_valid_out && exp_pop_ok) begin
                mon_have = 1'b0;
                if (o_chan_in == 1'b0 && q0.size() > 0) begin
                    mon_exp = q0.pop_front(); mon_have = 1'b1;
                end else if (o_chan_in == 1'b1 && q1.size() > 0) begin
                    mon_exp = q1.pop_front(); mon_have = 1'b1;
                end
                chk("pop_have_expected", mon_have, 1);
                if (mon_have) chk("pop_data", {o_tag_out, o_dst_out, o_vc_out}, mon_exp);
            end
        end
    end

    task automatic drive_set(input logic pv, input logic pc, input logic [7:0] tg,
                             input logic [3:0] ds, input logic vc,
                             input logic rv, input logic rc);
        logic [12:0] e;
        i_valid_in = pv; i_chan_in = pc; i_tag_in = tg; i_dst_in = ds; i_vc_in = vc;
        o_valid_in = rv; o_chan_in = rc;
        m_acc = pv && (mcnt[pc] < DEPTH);
        m_pok = rv && (mcnt[rc] > 0);
        byp_cyc = 1'b0;
`ifdef DEST_TAG_TRACKER_BYPASS_EN
        if (pv && rv && pc == rc && mcnt[pc] == 0) begin
            m_pok = 1'b1; byp_cyc = 1'b1;
        end
`endif
        m_pc = pc; m_rc = rc;
        exp_pop_ok = m_pok;
        if (pv && !m_acc) m_ovf = 1'b1;
        if (rv && !m_pok) m_unf = 1'b1;
        e = {tg, ds, vc};
        if (m_acc) begin
            if (pc == 1'b0) q0.push_back(e);
            else            q1.push_back(e);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk); #1;
        if (!byp_cyc) begin
            if (m_acc) mcnt[m_pc]++;
            if (m_pok) mcnt[m_rc]--;
        end
        byp_cyc = 1'b0;
    endtask

    task automatic check_state();
        chk("count0", o_count_out[0 +: CNT_W], mcnt[0]);
        chk("count1", o_count_out[CNT_W +: CNT_W], mcnt[1]);
        chk("afull0", o_afull_out[0], mcnt[0] >= AF);
        chk("afull1", o_afull_out[1], mcnt[1] >= AF);
        chk("ready", i_ready_out, mcnt[i_chan_in] < DEPTH);
        chk("err_ovf", err_overflow_out, m_ovf);
        chk("err_unf", err_underflow_out, m_unf);
    endtask

    task automatic step(input logic pv, input logic pc, input logic [7:0] tg,
                        input logic [3:0] ds, input logic vc,
                        input logic rv, input logic rc);
        drive_set(pv, pc, tg, ds, vc, rv, rc);
        drive_edge();
        check_state();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, o_valid_out, 0);
        chk({tag, "_data"}, {o_tag_out, o_dst_out, o_vc_out}, 0);
        chk({tag, "_count"}, o_count_out, 0);
        chk({tag, "_afull"}, o_afull_out, 0);
        chk({tag, "_ready"}, i_ready_out, 1);
        chk({tag, "_ovf"}, err_overflow_out, 0);
        chk({tag, "_unf"}, err_underflow_out, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mcnt[0] = 0; mcnt[1] = 0; m_ovf = 0; m_unf = 0; exp_pop_ok = 0; byp_cyc = 0;
        i_valid_in = 0; o_valid_in = 0; i_chan_in = 0; o_chan_in = 0;
        i_tag_in = 0; i_dst_in = 0; i_vc_in = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single push then head visible next cycle
        step(1, 0, 8'h11, 4'd3, 1'b1, 0, 0);
        chk("t1_head_valid", o_valid_out, 1);
        chk("t1_head_tag", o_tag_out, 8'h11);
        chk("t1_head_dst", o_dst_out, 4'd3);
        chk("t1_head_vc", o_vc_out, 1'b1);
        chk("t1_count0", o_count_out[3:0], 1);
        chk("t1_count1", o_count_out[7:4], 0);
        step(0, 0, 8'h00, 4'd0, 1'b0, 1, 0);

        // Fill channel 1, overflow, drain through the wrap
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 1, 8'(i), 4'(i), 1'(i), 0, 0);
            if (i == 8) chk("t2_afull_at9", o_afull_out[1], 0);
            if (i == 9) chk("t2_afull_at10", o_afull_out[1], 1);
        end
        chk("t2_ready_full", i_ready_out, 0);
        chk("t2_count_full", o_count_out[7:4], 12);
        step(1, 1, 8'hEE, 4'hE, 1'b0, 0, 0);
        chk("t2_overflow", err_overflow_out, 1);
        chk("t2_count_after_ovf", o_count_out[7:4], 12);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00, 4'd0, 1'b0, 1, 1);
        chk("t2_drained", o_count_out[7:4], 0);

        // Underflow on the empty channel
        step(0, 0, 8'h00, 4'd0, 1'b0, 1, 1);
        chk("t3_underflow", err_underflow_out, 1);
        chk("t3_counts", o_count_out, 0);

        // Steady occupancy 5 on channel 0 with simultaneous push/pop
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h20 + i), 4'(i), 1'(i), 0, 0);
        for (int i = 0; i < 30; i++) step(1, 0, 8'(8'h40 + i), 4'(i + 5), 1'(i), 1, 0);
        chk("t4_count_steady", o_count_out[3:0], 5);

        // Build counts 7/3, then reset asynchronously mid-cycle
        step(1, 0, 8'h60, 4'd1, 1'b0, 0, 0);
        step(1, 0, 8'h61, 4'd2, 1'b1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 8'(8'h70 + i), 4'(i), 1'b0, 0, 0);
        chk("t5_pre_counts", o_count_out, {4'd3, 4'd7});
        chk("t5_unf_sticky", err_underflow_out, 1);
        #3;
        i_valid_in = 1'b1; i_chan_in = 1'b1;
        rst = 1'b1;
        #1;
        check_reset_outputs("t5_async");
        mcnt[0] = 0; mcnt[1] = 0; m_ovf = 0; m_unf = 0;
        q0.delete(); q1.delete();
        i_valid_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        step(1, 0, 8'h5A, 4'hA, 1'b0, 0, 0);
        chk("t5_head_valid", o_valid_out, 1);
        chk("t5_head_tag", o_tag_out, 8'h5A);
        chk("t5_head_dst", o_dst_out, 4'hA);
        step(0, 0, 8'h00, 4'd0, 1'b0, 1, 0);

        // Push into empty channel 0 with same-cycle pop
        drive_set(1, 0, 8'h77, 4'h6, 1'b1, 1, 0);
        #2;
`ifdef DEST_TAG_TRACKER_BYPASS_EN
        chk("t6_byp_valid", o_valid_out, 1);
        chk("t6_byp_tag", o_tag_out, 8'h77);
        chk("t6_byp_dst", o_dst_out, 4'h6);
        chk("t6_byp_vc", o_vc_out, 1'b1);
`else
        chk("t6_nobyp_valid", o_valid_out, 0);
        chk("t6_nobyp_tag", o_tag_out, 8'h00);
`endif
        drive_edge();
        check_state();
`ifdef DEST_TAG_TRACKER_BYPASS_EN
        chk("t6_byp_count", o_count_out[3:0], 0);
`else
        chk("t6_nobyp_count", o_count_out[3:0], 1);
        step(0, 0, 8'h00, 4'd0, 1'b0, 1, 0);
`endif
        step(0, 0, 8'h00, 4'd0, 1'b0, 0, 0);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
